// File: rtl/txuart_sched.sv
// Round-robin scheduler sharing one txuart transmitter between NREQ byte-stream
// requesters; a grant is held from a message's first byte through its last byte.
module txuart_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NREQ-1:0]     i_req_valid,
  input  logic [8*NREQ-1:0]   i_req_data,
  input  logic [NREQ-1:0]     i_req_last,
  output logic [NREQ-1:0]     o_req_ready,
  output logic                o_uart_write,
  output logic [7:0]          o_uart_data,
  input  logic                i_uart_busy,
  output logic [IDW-1:0]      o_owner,
  output logic                o_active
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  last_owner, last_owner_d;
  logic [IDW-1:0]  owner_d;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            found;
  logic            last_flag, last_flag_d;
  logic            write_d;
  logic [7:0]      data_d;
  logic            active_d;
  logic            xfer;
  logic [7:0]      owner_byte;

  // Round-robin search upward from the requester after the previous owner.
  always_comb begin
    winner = last_owner;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(last_owner) + i) % NREQ);
      if (!found && i_req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Only the owner may transfer, and only while the UART is idle.
  always_comb begin
    o_req_ready = '0;
    xfer        = (state == FETCH) && i_req_valid[o_owner] && !i_uart_busy;
    owner_byte  = i_req_data[32'(o_owner)*8 +: 8];
    if (xfer) begin
      o_req_ready[o_owner] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state;
    write_d      = 1'b0;
    data_d       = o_uart_data;
    owner_d      = o_owner;
    active_d     = o_active;
    last_owner_d = last_owner;
    last_flag_d  = last_flag;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d  = winner;
          active_d = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (xfer) begin
          data_d      = owner_byte;
          last_flag_d = i_req_last[o_owner];
          write_d     = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        // Dead cycle so txuart can raise busy before the next fetch.
        if (last_flag) begin
          last_owner_d = o_owner;
          active_d     = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      o_uart_write <= 1'b0;
      o_uart_data  <= 8'h00;
      o_owner      <= '0;
      o_active     <= 1'b0;
      last_owner   <= IDW'(NREQ - 1);
      last_flag    <= 1'b0;
    end else begin
      state        <= state_d;
      o_uart_write <= write_d;
      o_uart_data  <= data_d;
      o_owner      <= owner_d;
      o_active     <= active_d;
      last_owner   <= last_owner_d;
      last_flag    <= last_flag_d;
    end
  end

endmodule

// File: tb/tb_txuart_sched.sv
// Bench for txuart_sched: message-level round-robin reference model feeding a
// scoreboard, with a txuart busy model and per-requester byte-stream drivers.
module tb_txuart_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam int          LIMIT = 5000;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                uart_write;
  logic [7:0]          uart_data;
  logic                uart_busy;
  logic [IDW-1:0]      owner;
  logic                active;

  always #5 clk = ~clk;

  txuart_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_uart_write (uart_write),
    .o_uart_data  (uart_data),
    .i_uart_busy  (uart_busy),
    .o_owner      (owner),
    .o_active     (active)
  );

  // Per-requester byte store {last, data}; stimulus appends, drivers consume.
  logic [8:0]  mem [NREQ][DEPTH];
  int          wr_ptr [NREQ];
  int          rd_ptr [NREQ];
  int          mdl_ptr [NREQ];
  int          gap [NREQ];
  int          mdl_last;
  int          busy_cnt;
  int          busy_len;
  int          gap_max;
  int          stall_req;
  int          stall_len;
  logic        force_busy;
  logic [11:0] exp_q [$];
  int          checks;
  int          failures;
  int          fall_cnt;
  logic [NREQ-1:0] drv_xfer;
  logic        drv_wr;

  assign uart_busy = (busy_cnt > 0) || force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Requester drivers and txuart busy model, updated just after each rising edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    busy_cnt  = 0;
    for (int r = 0; r < NREQ; r++) begin
      rd_ptr[r] = 0;
      gap[r]    = 0;
    end
    forever begin
      @(negedge clk);
      drv_xfer = req_valid & req_ready;
      drv_wr   = uart_write;
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
        for (int r = 0; r < NREQ; r++) begin
          rd_ptr[r] = wr_ptr[r];
          gap[r]    = 0;
        end
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        if (drv_wr) busy_cnt = busy_len;
        for (int r = 0; r < NREQ; r++) begin
          if (drv_xfer[r]) begin
            if (mem[r][rd_ptr[r]][8]) gap[r] = 0;
            else if (r == stall_req) gap[r] = stall_len;
            else gap[r] = $urandom_range(0, gap_max);
            rd_ptr[r]++;
          end else if (gap[r] > 0) begin
            gap[r]--;
          end
        end
      end
      for (int r = 0; r < NREQ; r++) begin
        if (rd_ptr[r] < wr_ptr[r] && gap[r] == 0) begin
          req_valid[r]        = 1'b1;
          req_data[8*r +: 8]  = mem[r][rd_ptr[r]][7:0];
          req_last[r]         = mem[r][rd_ptr[r]][8];
        end else begin
          req_valid[r]        = 1'b0;
          req_data[8*r +: 8]  = 8'h00;
          req_last[r]         = 1'b0;
        end
      end
    end
  end

  // Monitor: ready legality every cycle, write pulses against the scoreboard.
  initial begin
    logic [11:0] e;
    logic        ok;
    fall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        fall_cnt = 0;
      end else begin
        ok = $onehot0(req_ready) && ((req_ready & ~req_valid) == '0) &&
             (req_ready == '0 || (active && !uart_busy && req_ready == (NREQ'(1) << owner)));
        chk("ready_rule", 32'(ok), 32'd1);
        if (fall_cnt == 2) begin
          chk("active_in_settle", 32'(active), 32'd1);
          fall_cnt = 1;
        end else if (fall_cnt == 1) begin
          chk("active_after_last", 32'(active), 32'd0);
          fall_cnt = 0;
        end
        if (uart_write) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual=%0h required=none t=%0t", uart_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("wr_data", 32'(uart_data), 32'(e[7:0]));
            chk("wr_owner", 32'(owner), 32'(e[11:9]));
            chk("wr_active", 32'(active), 32'd1);
            if (e[8]) fall_cnt = 2;
          end
        end
      end
    end
  end

  task automatic load_byte(input int r, input logic last, input logic [7:0] d);
    mem[r][wr_ptr[r]] = {last, d};
    wr_ptr[r]++;
  endtask

  task automatic load_msg(input int r, input int len);
    for (int k = 0; k < len; k++) load_byte(r, (k == len - 1), 8'($urandom));
  endtask

  // Message-level reference: each new grant goes to the first requester with
  // an unsent message, searching upward from the previous grant holder.
  task automatic plan();
    int          r;
    int          c;
    bit          found;
    logic [8:0]  e;
    forever begin
      found = 1'b0;
      r = 0;
      for (int i = 1; i <= NREQ; i++) begin
        c = (mdl_last + i) % NREQ;
        if (!found && mdl_ptr[c] < wr_ptr[c]) begin
          r = c;
          found = 1'b1;
        end
      end
      if (!found) break;
      do begin
        e = mem[r][mdl_ptr[r]];
        mdl_ptr[r]++;
        exp_q.push_back({3'(r), e});
      end while (!e[8]);
      mdl_last = r;
    end
  endtask

  task automatic model_reset();
    mdl_last = NREQ - 1;
    for (int r = 0; r < NREQ; r++) mdl_ptr[r] = wr_ptr[r];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_write", 32'(uart_write), 32'd0);
    chk("rst_data", 32'(uart_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  function automatic bit pending();
    for (int r = 0; r < NREQ; r++) if (rd_ptr[r] != wr_ptr[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || active || pending()) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < LIMIT), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_write(input string name, input bit need_owner, input int want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(uart_write && (!need_owner || int'(owner) == want)) && n < LIMIT);
    chk(name, 32'(n < LIMIT), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    force_busy = 1'b0;
    busy_len   = 10;
    gap_max    = 0;
    stall_req  = -1;
    stall_len  = 0;
    checks     = 0;
    failures   = 0;
    for (int r = 0; r < NREQ; r++) wr_ptr[r] = 0;
    model_reset();

    // Single two-byte message from requester 0.
    do_reset();
    load_byte(0, 1'b0, 8'h48);
    load_byte(0, 1'b1, 8'h65);
    plan();
    drain("drain_single");

    // Round-robin over four always-valid requesters.
    do_reset();
    busy_len = 3;
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NREQ; r++) load_msg(r, 1);
    plan();
    drain("drain_rr");

    // Message lock: requester 1 arrives while requester 2 is mid-message.
    do_reset();
    busy_len = 4;
    load_msg(2, 3);
    plan();
    wait_write("lock_first_write", 1'b0, 0);
    load_msg(1, 1);
    plan();
    drain("drain_lock");

    // Owner stall: requester 3 goes quiet between bytes while others wait.
    do_reset();
    busy_len  = 4;
    stall_req = 3;
    stall_len = 20;
    load_msg(0, 1);
    load_msg(3, 2);
    plan();
    wait_write("stall_first_write", 1'b1, 3);
    load_msg(1, 1);
    plan();
    repeat (15) begin
      @(negedge clk);
      chk("stall_write", 32'(uart_write), 32'd0);
      chk("stall_active", 32'(active), 32'd1);
      chk("stall_owner", 32'(owner), 32'd3);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    drain("drain_stall");
    stall_req = -1;

    // Busy gating: no ready while the UART reports busy.
    do_reset();
    busy_len   = 3;
    force_busy = 1'b1;
    load_msg(1, 2);
    plan();
    repeat (50) begin
      @(negedge clk);
      chk("gate_ready", 32'(req_ready), 32'd0);
      chk("gate_write", 32'(uart_write), 32'd0);
    end
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    @(negedge clk);
    chk("gate_xfer", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("gate_pulse", 32'(uart_write), 32'd1);
    drain("drain_gate");

    // Randomized traffic.
    for (int round = 0; round < 30; round++) begin
      if ($urandom_range(0, 4) == 0) do_reset();
      busy_len = $urandom_range(1, 12);
      gap_max  = $urandom_range(0, 3);
      for (int r = 0; r < NREQ; r++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) load_msg(r, $urandom_range(1, 4));
      end
      plan();
      drain("drain_random");
    end
    gap_max = 0;

    // Reset asserted during ISSUE, then requester 0 must win first.
    busy_len = 5;
    load_msg(1, 3);
    load_msg(2, 2);
    plan();
    wait_write("mid_first_write", 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", 32'(uart_write), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_data", 32'(uart_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    load_msg(2, 1);
    load_msg(0, 1);
    plan();
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
